// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: pipeline request/response and data-memory signals of the load/store unit
interface lsu_mem_stage_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [2:0]            req_size_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [15:0]           req_wdata_i;
    logic                  resp_valid_o;
    logic [15:0]           resp_rdata_o;
    logic                  resp_err_o;
    logic [ADDR_WIDTH-1:0] dmem_addr_o;
    logic [15:0]           dmem_wdata_o;
    logic                  dmem_write_o;
    logic                  dmem_read_o;
    logic [15:0]           dmem_rdata_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, dmem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               dmem_addr_o, dmem_wdata_o, dmem_write_o, dmem_read_o
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, dmem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               dmem_addr_o, dmem_wdata_o, dmem_write_o, dmem_read_o
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: byte-addressed load/store unit driving a word-wide synchronous data memory
module lsu_mem_stage #(
    parameter int ADDR_WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    lsu_mem_stage_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  req_err;
    logic [7:0]            rd_byte;
    logic [15:0]           load_word;
    logic [15:0]           merged_word;

    // Request legality and the byte-lane datapath around the memory read word
    always_comb begin
        req_err     = !(bus.req_size_i == 3'b000 || bus.req_size_i == 3'b001 || bus.req_size_i == 3'b100)
                      || (bus.req_size_i == 3'b001 && bus.req_addr_i[0]);
        rd_byte     = addr_q[0] ? bus.dmem_rdata_i[15:8] : bus.dmem_rdata_i[7:0];
        load_word   = size_q == 3'b000 ? {{8{rd_byte[7]}}, rd_byte} :
                      size_q == 3'b100 ? {8'h00, rd_byte} : bus.dmem_rdata_i;
        merged_word = addr_q[0] ? {wdata_q[7:0], bus.dmem_rdata_i[7:0]}
                                : {bus.dmem_rdata_i[15:8], wdata_q[7:0]};
    end

    // Next-state: latch on accept, then walk read / merge / write / respond
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    write_d = bus.req_write_i;
                    size_d  = bus.req_size_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    err_d   = req_err;
                    state_d = req_err ? RESP :
                              (bus.req_write_i && bus.req_size_i == 3'b001) ? WR : RD;
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: begin
                // Byte stores reuse the write-data register to hold the merged word
                if (write_q) begin
                    wdata_d = merged_word;
                    state_d = WR;
                end else begin
                    rdata_d = load_word;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only from state and latched registers
    always_comb begin
        bus.req_ready_o  = state_q == IDLE;
        bus.resp_valid_o = state_q == RESP;
        bus.resp_err_o   = state_q == RESP && err_q;
        bus.resp_rdata_o = (state_q == RESP && (write_q || err_q)) ? 16'h0000 : rdata_q;
        bus.dmem_read_o  = state_q == RD;
        bus.dmem_write_o = state_q == WR;
        bus.dmem_wdata_o = state_q == WR ? wdata_q : 16'h0000;
        bus.dmem_addr_o  = {1'b0, addr_q[ADDR_WIDTH-1:1]};
    end

    // State and request registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: vector table, corner sequences and randomized model check of lsu_mem_stage
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    lsu_mem_stage_if #(.ADDR_WIDTH(16)) bus ();

    lsu_mem_stage #(.ADDR_WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous data memory with a bench-side preload port
    logic [15:0] mem [0:32767];
    logic        pl_en = 1'b0;
    logic [14:0] pl_idx = '0;
    logic [15:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (bus.dmem_write_o) mem[bus.dmem_addr_o[14:0]] <= bus.dmem_wdata_o;
        if (bus.dmem_read_o) bus.dmem_rdata_i <= mem[bus.dmem_addr_o[14:0]];
    end

    // Strobe monitor
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          ovl_cnt = 0;
    int          addr_hi = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] last_wdata = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dmem_read_o) begin rd_cnt++; last_addr = bus.dmem_addr_o; end
            if (bus.dmem_write_o) begin wr_cnt++; last_addr = bus.dmem_addr_o; last_wdata = bus.dmem_wdata_o; end
            if (bus.dmem_read_o && bus.dmem_write_o) ovl_cnt++;
            if (!bus.dmem_read_o && !bus.dmem_write_o && bus.dmem_wdata_o != 16'h0000) ovl_cnt++;
            if (bus.dmem_addr_o[15]) addr_hi++;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic preload(input logic [14:0] idx, input logic [15:0] d);
        pl_idx = idx; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1 pl_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_req(input logic w, input logic [2:0] sz, input logic [15:0] a, input logic [15:0] wd,
                          output int lat, output logic e, output logic [15:0] rd, output int nr, output int nw);
        int g, r0, w0;
        g = 0;
        while (!bus.req_ready_o && g < 20) begin @(negedge clk); g++; end
        chk("ready_wait", {31'd0, bus.req_ready_o}, 32'd1);
        r0 = rd_cnt; w0 = wr_cnt;
        bus.req_write_i = w; bus.req_size_i = sz; bus.req_addr_i = a; bus.req_wdata_i = wd;
        bus.req_valid_i = 1'b1;
        @(posedge clk); #1 bus.req_valid_i = 1'b0;
        lat = -1; e = 1'b0; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid_o) begin
                lat = k; e = bus.resp_err_o; rd = bus.resp_rdata_o;
                break;
            end
        end
        nr = rd_cnt - r0; nw = wr_cnt - w0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [15:0] a;
        logic [15:0] wd;
        logic        pre_en;
        logic [15:0] pre;
        int          lat;
        logic        e;
        logic [15:0] rd;
        logic [15:0] post;
    } vec_t;

    vec_t        tbl [14];
    logic [15:0] ref_mem [0:32767];
    logic [2:0]  size_pool [11];

    initial begin
        int          lat, nr, nw, exp_lat, exp_nr, exp_nw, bad;
        logic        e, exp_e, wr;
        logic [2:0]  sz;
        logic [14:0] idx;
        logic [15:0] rd, a, wd, w, b, exp_rd, last_ld;

        tbl[0]  = '{1'b1, 3'b001, 16'h0010, 16'hBEEF, 1'b1, 16'h0000, 2, 1'b0, 16'h0000, 16'hBEEF};
        tbl[1]  = '{1'b0, 3'b000, 16'h0011, 16'h0000, 1'b1, 16'h8000, 3, 1'b0, 16'hFF80, 16'h8000};
        tbl[2]  = '{1'b0, 3'b100, 16'h0011, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h0080, 16'h8000};
        tbl[3]  = '{1'b0, 3'b000, 16'h0010, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h0000, 16'h8000};
        tbl[4]  = '{1'b1, 3'b000, 16'h0011, 16'h12AB, 1'b1, 16'hBEEF, 4, 1'b0, 16'h0000, 16'hABEF};
        tbl[5]  = '{1'b0, 3'b001, 16'h0010, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'hABEF, 16'hABEF};
        tbl[6]  = '{1'b0, 3'b001, 16'h0013, 16'h0000, 1'b1, 16'h1234, 1, 1'b1, 16'h0000, 16'h1234};
        tbl[7]  = '{1'b0, 3'b010, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 16'h0000, 16'hABEF};
        tbl[8]  = '{1'b1, 3'b000, 16'h0010, 16'h00CD, 1'b1, 16'h1234, 4, 1'b0, 16'h0000, 16'h12CD};
        tbl[9]  = '{1'b0, 3'b000, 16'hFFFF, 16'h0000, 1'b1, 16'h7F00, 3, 1'b0, 16'h007F, 16'h7F00};
        tbl[10] = '{1'b0, 3'b100, 16'hFFFF, 16'h0000, 1'b1, 16'h8A00, 3, 1'b0, 16'h008A, 16'h8A00};
        tbl[11] = '{1'b0, 3'b001, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 16'h8A00, 16'h8A00};
        tbl[12] = '{1'b1, 3'b001, 16'h0013, 16'h5555, 1'b1, 16'h4321, 1, 1'b1, 16'h0000, 16'h4321};
        tbl[13] = '{1'b1, 3'b111, 16'h0020, 16'h5555, 1'b1, 16'h0F0F, 1, 1'b1, 16'h0000, 16'h0F0F};
        size_pool = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b001, 3'b100, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

        rst_n = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = '0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err_o}, 32'd0);
        chk("rst_rdata", {16'd0, bus.resp_rdata_o}, 32'd0);
        chk("rst_strobes", {30'd0, bus.dmem_read_o, bus.dmem_write_o}, 32'd0);
        chk("rst_dmem_addr", {16'd0, bus.dmem_addr_o}, 32'd0);
        chk("rst_dmem_wdata", {16'd0, bus.dmem_wdata_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].pre_en) preload(tbl[i].a[15:1], tbl[i].pre);
            do_req(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, lat, e, rd, nr, nw);
            exp_nr = (!tbl[i].e && (!tbl[i].w || tbl[i].sz != 3'b001)) ? 1 : 0;
            exp_nw = (!tbl[i].e && tbl[i].w) ? 1 : 0;
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].e});
            chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, tbl[i].rd});
            chk($sformatf("vec%0d_reads", i), nr, exp_nr);
            chk($sformatf("vec%0d_writes", i), nw, exp_nw);
            chk($sformatf("vec%0d_mem", i), {16'd0, mem[tbl[i].a[15:1]]}, {16'd0, tbl[i].post});
            if (exp_nr + exp_nw > 0)
                chk($sformatf("vec%0d_dmem_addr", i), {16'd0, last_addr}, {17'd0, tbl[i].a[15:1]});
            if (exp_nw > 0)
                chk($sformatf("vec%0d_dmem_wdata", i), {16'd0, last_wdata}, {16'd0, tbl[i].post});
        end

        // Asynchronous reset during RD and during RD_WAIT
        for (int s = 1; s <= 2; s++) begin
            @(negedge clk);
            bus.req_write_i = 1'b0; bus.req_size_i = 3'b000; bus.req_addr_i = 16'h0010;
            bus.req_valid_i = 1'b1;
            @(posedge clk); #1 bus.req_valid_i = 1'b0;
            repeat (s) @(negedge clk);
            if (s == 1) chk("pre_rst_read", {31'd0, bus.dmem_read_o}, 32'd1);
            #2 rst_n = 1'b0;
            #1;
            chk($sformatf("midrst%0d_read", s), {31'd0, bus.dmem_read_o}, 32'd0);
            chk($sformatf("midrst%0d_ready", s), {31'd0, bus.req_ready_o}, 32'd1);
            chk($sformatf("midrst%0d_resp", s), {31'd0, bus.resp_valid_o}, 32'd0);
            @(negedge clk);
            chk($sformatf("midrst%0d_idle", s), {29'd0, bus.resp_valid_o, bus.dmem_read_o, bus.dmem_write_o}, 32'd0);
            rst_n = 1'b1;
        end

        // Back-to-back halfword loads with valid held high
        preload(15'h0008, 16'h1111);
        preload(15'h0009, 16'h2222);
        bus.req_write_i = 1'b0; bus.req_size_i = 3'b001; bus.req_addr_i = 16'h0010;
        bus.req_valid_i = 1'b1;
        @(posedge clk); #1 bus.req_addr_i = 16'h0012;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_t%0d", k), {31'd0, bus.req_ready_o}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_resp_t%0d", k), {31'd0, bus.resp_valid_o}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
            if (k == 3) chk("b2b_rdata1", {16'd0, bus.resp_rdata_o}, 32'h1111);
            if (k == 7) chk("b2b_rdata2", {16'd0, bus.resp_rdata_o}, 32'h2222);
            if (k == 4) begin @(posedge clk); #1 bus.req_valid_i = 1'b0; end
        end
        last_ld = 16'h2222;

        // Randomized requests against a word-array model
        for (int i = 0; i < 64; i++) begin
            w = 16'($urandom); ref_mem[i] = w; preload(15'(i), w);
        end
        w = 16'($urandom); ref_mem[32767] = w; preload(15'h7FFF, w);
        for (int n = 0; n < 300; n++) begin
            idx = ($urandom_range(9) == 0) ? 15'h7FFF : 15'($urandom_range(63));
            a   = {idx, 1'($urandom)};
            sz  = size_pool[$urandom_range(10)];
            wr  = 1'($urandom);
            wd  = 16'($urandom);
            w   = ref_mem[idx];
            b   = (w >> (8 * a[0])) & 16'h00FF;
            exp_e  = !(sz == 3'b000 || sz == 3'b001 || sz == 3'b100) || (sz == 3'b001 && a[0]);
            exp_rd = 16'h0000;
            exp_nr = 0; exp_nw = 0;
            if (exp_e) exp_lat = 1;
            else if (!wr) begin
                exp_lat = 3; exp_nr = 1;
                exp_rd = (sz == 3'b001) ? w : (sz == 3'b100) ? b : (b >= 16'd128 ? b + 16'hFF00 : b);
            end else if (sz == 3'b001) begin
                exp_lat = 2; exp_nw = 1; ref_mem[idx] = wd;
            end else begin
                exp_lat = 4; exp_nr = 1; exp_nw = 1;
                ref_mem[idx] = (w & ~(16'h00FF << (8 * a[0]))) | ((wd & 16'h00FF) << (8 * a[0]));
            end
            do_req(wr, sz, a, wd, lat, e, rd, nr, nw);
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
            chk($sformatf("rnd%0d_err", n), {31'd0, e}, {31'd0, exp_e});
            chk($sformatf("rnd%0d_rdata", n), {16'd0, rd}, {16'd0, exp_rd});
            chk($sformatf("rnd%0d_strobes", n), nr * 4 + nw, exp_nr * 4 + exp_nw);
            if (!exp_e && !wr) last_ld = exp_rd;
            @(negedge clk);
            chk($sformatf("rnd%0d_resp_pulse", n), {31'd0, bus.resp_valid_o}, 32'd0);
            chk($sformatf("rnd%0d_rdata_hold", n), {16'd0, bus.resp_rdata_o}, {16'd0, last_ld});
        end

        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        if (mem[32767] !== ref_mem[32767]) bad++;
        chk("final_mem_words", bad, 0);
        chk("strobe_exclusive", ovl_cnt, 0);
        chk("dmem_addr_top_bit", addr_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the 16-bit core's memory stage; sits directly upstream of the synchronous word-wide data memory.
- Accepts one byte-addressed load/store request at a time from the pipeline and converts it into word-indexed dmem read/write strobes.
- Performs read-modify-write for byte stores, and byte extraction plus sign/zero extension for loads.
- Returns a single-cycle response and stalls the pipeline (req_ready_o low) while busy.

Parameters:
- ADDR_WIDTH, 16, width of req_addr_i and dmem_addr_o; data width fixed at 16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit idle, request accepted when valid&ready
- req_write_i  in  1  1=store, 0=load
- req_size_i  in  3  000=byte signed (LB/SB), 001=halfword (LH/SH), 100=byte unsigned (LBU)
- req_addr_i  in  ADDR_WIDTH  byte address (ALU result)
- req_wdata_i  in  16  store data (rs2)
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  16  extended load result
- resp_err_o  out  1  misaligned or illegal-size request, qualified by resp_valid_o
- dmem_addr_o  out  ADDR_WIDTH  word index = {1'b0, addr[ADDR_WIDTH-1:1]}
- dmem_wdata_o  out  16  word to write
- dmem_write_o  out  1  write strobe
- dmem_read_o  out  1  read strobe
- dmem_rdata_i  in  16  dmem registered read data, valid the cycle after dmem_read_o

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except req_ready_o=1.
  - Latched request registers cleared.
  - Reset mid-operation aborts immediately; any dmem strobe drops the same instant.
- Accept: in IDLE with req_valid_i=1, latch write/size/addr/wdata. Request inputs are ignored in every other state.
- dmem_* outputs decode only from the state and latched registers; there is no combinational path from req_* to dmem_*.
- Error detection at accept:
  - illegal = size not in {000,001,100}.
  - misaligned = size==001 & addr[0].
  - Either condition goes to RESP with err=1 and issues no dmem access.
- States:
  - IDLE: req_ready_o=1.
    - error -> RESP.
    - load or byte store -> RD.
    - halfword store -> WR.
  - RD: dmem_read_o=1 -> RD_WAIT.
  - RD_WAIT: sample dmem_rdata_i.
    - Load: byte selected by addr[0], little-endian (0 = bits[7:0], 1 = bits[15:8]).
      - size 000 sign-extends; size 100 zero-extends; size 001 passes the full word.
      - Result is registered, then -> RESP.
    - Byte store: merge wdata[7:0] into the selected byte lane, keep the other lane, register the merged word -> WR.
  - WR: dmem_write_o=1, dmem_wdata_o = merged word (byte store) or wdata (halfword store) -> RESP.
  - RESP: resp_valid_o=1 for exactly one cycle -> IDLE. req_ready_o=0.
- dmem_read_o and dmem_write_o are never high in the same cycle.
- Strobes and dmem_wdata_o are 0 outside RD/WR; dmem_addr_o holds the latched word index.
- resp_rdata_o:
  - Updated only on completed loads.
  - Stores and errors drive 0 in their RESP cycle.
  - Holds its value after RESP until the next response.
- Latency, with accept at cycle T:
  - error: resp_valid_o at T+1.
  - halfword store: WR at T+1, resp at T+2.
  - load: RD T+1, RD_WAIT T+2, resp T+3.
  - byte store: RD T+1, RD_WAIT T+2, WR T+3, resp T+4.
- req_ready_o falls the cycle after accept and returns high in the cycle following RESP.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP.
- Address wrap: the top address bit is discarded via the word index. Boundary example: address 16'hFFFF byte → word 16'h7FFF, upper lane.

Test Plan:
- Reset: assert rst_n=0 mid-RD_WAIT -> state IDLE immediately, dmem_read_o=0, req_ready_o=1, resp_valid_o=0.
- SH addr 16'h0010, wdata 16'hBEEF -> T+1 dmem_write_o=1, dmem_addr_o=16'h0008, dmem_wdata_o=16'hBEEF; T+2 resp_valid_o=1, err=0.
- LB/LBU with word 16'h8000 at index 8:
  - LB addr 16'h0011 -> resp_rdata_o=16'hFF80 at T+3.
  - LBU addr 16'h0011 -> 16'h0080.
  - LB addr 16'h0010 -> 16'h0000.
- SB addr 16'h0011, wdata 16'h12AB, memory word 16'hBEEF -> T+1 read, T+3 dmem_wdata_o=16'hABEF write, T+4 resp; subsequent LH addr 16'h0010 returns 16'hABEF.
- Errors -> resp_valid_o=1, resp_err_o=1 at T+1, with no dmem strobe in either case:
  - LH addr 16'h0013.
  - size 3'b010.
- Back-to-back: hold req_valid_i high for two LH requests -> second accepted exactly one cycle after the first RESP; req_ready_o low for T+1..T+3.
